// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. It takes a program image as a
// byte stream over a valid/ready handshake and assembles big-endian 32-bit
// words. Each completed word goes out as a one-cycle write on the IMem write
// port. The core is held in reset until the whole image has been received and
// its XOR checksum matches.
//
// Stream layout:
//   CNT_HI, CNT_LO, N x {b31..24, b23..16, b15..8, b7..0}, CHK
// CHK is the XOR of every byte before it, including both count bytes.
//
// Parameters
//   ADDR_BITS   word-address width; the memory holds 2^ADDR_BITS words
//   BASE_ADDR   byte address of the first loaded word (must be word-aligned)
//
// Ports
//   clock        system clock; all state changes on the rising edge
//   reset        synchronous, active-low reset
//   in_valid     a stream byte is offered on in_data
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle (transfer = valid & ready)
//   wr_en        IMem write strobe, one cycle per word
//   wr_addr      IMem byte address of the word being written
//   wr_data      IMem write data
//   cpu_reset_n  0 holds the core in reset, 1 releases it
//   done         image loaded and checksum correct (terminal)
//   error        image rejected: oversize count or bad checksum (terminal)
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset_n,
    output logic        done,
    output logic        error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_CNT_HI = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CHK    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    // Largest legal word count. A count equal to the capacity is allowed.
    localparam int unsigned CAPACITY = 32'd1 << ADDR_BITS;

    // Word index is one bit wider than the address so a full-capacity image
    // can be counted all the way to its end.
    localparam int unsigned IDX_W = ADDR_BITS + 1;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [2:0]       state_q,       state_d;
    logic [15:0]      count_q,       count_d;
    logic [IDX_W-1:0] word_idx_q,    word_idx_d;
    logic [1:0]       byte_idx_q,    byte_idx_d;
    logic [31:0]      asm_q,         asm_d;
    logic [7:0]       xor_q,         xor_d;

    // Registered outputs
    logic             in_ready_q,    in_ready_d;
    logic             wr_en_q,       wr_en_d;
    logic [31:0]      wr_addr_q,     wr_addr_d;
    logic [31:0]      wr_data_q,     wr_data_d;
    logic             cpu_reset_n_q, cpu_reset_n_d;
    logic             done_q,        done_d;
    logic             error_q,       error_d;

    // ------------------------------------------------------------------------
    // Helper signals
    // ------------------------------------------------------------------------
    logic             accept;
    logic [31:0]      count_full;
    logic [IDX_W-1:0] word_idx_inc;
    logic [31:0]      word_word;
    logic [31:0]      word_offset;

    // in_ready_q is a decode of the current state, so gating with it makes a
    // byte offered in S_DONE or S_ERR a non-event.
    assign accept       = in_valid & in_ready_q;

    // Full count as it stands once CNT_LO is on the bus.
    assign count_full   = {16'h0000, count_q[15:8], in_data};

    assign word_idx_inc = word_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};

    // Word being completed by the current byte (MSB first).
    assign word_word    = {asm_q[23:0], in_data};

    // Byte offset of the current word; plain 32-bit arithmetic, no wrap check.
    assign word_offset  = 32'(word_idx_q) << 2;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_CNT_HI: begin
                if (accept) begin
                    count_d[15:8] = in_data;
                    xor_d         = xor_q ^ in_data;
                    state_d       = S_CNT_LO;
                end
            end

            S_CNT_LO: begin
                if (accept) begin
                    count_d[7:0] = in_data;
                    xor_d        = xor_q ^ in_data;
                    if (count_full > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (count_full == 32'd0) begin
                        // Empty image: only the checksum byte follows.
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    asm_d      = word_word;
                    xor_d      = xor_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Fourth byte of a word: launch the write next cycle.
                        wr_en_d    = 1'b1;
                        wr_data_d  = word_word;
                        wr_addr_d  = BASE_ADDR + word_offset;
                        word_idx_d = word_idx_inc;
                        if (32'(word_idx_inc) == {16'h0000, count_q}) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end

            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
            end

            S_DONE: state_d = S_DONE;

            S_ERR: state_d = S_ERR;

            // Unused encodings are treated as a rejected image.
            default: state_d = S_ERR;
        endcase

        // Outputs are decoded from the next state so they line up with it.
        in_ready_d    = (state_d == S_CNT_HI) || (state_d == S_CNT_LO) ||
                        (state_d == S_DATA)   || (state_d == S_CHK);
        done_d        = (state_d == S_DONE);
        error_d       = (state_d == S_ERR);
        cpu_reset_n_d = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------------
    // Sequential state, synchronous active-low reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= S_CNT_HI;
            count_q       <= 16'h0000;
            word_idx_q    <= '0;
            byte_idx_q    <= 2'd0;
            asm_q         <= 32'h0000_0000;
            xor_q         <= 8'h00;
            in_ready_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 32'h0000_0000;
            wr_data_q     <= 32'h0000_0000;
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            word_idx_q    <= word_idx_d;
            byte_idx_q    <= byte_idx_d;
            asm_q         <= asm_d;
            xor_q         <= xor_d;
            in_ready_q    <= in_ready_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
